single_port_blockram_arbiter: RTL

//  Shares one single_port_blockram instance between NUM_REQUESTER clients with fair round-robin arbitration.

---
 rtl/single_port_blockram_arbiter_pkg.sv | 17 +
 rtl/single_port_blockram_arbiter_ram.sv | 24 ++
 rtl/single_port_blockram_arbiter_rr.sv | 28 ++
 rtl/single_port_blockram_arbiter.sv | 128 ++++++++++++
 4 files changed

// File: rtl/single_port_blockram_arbiter_pkg.sv
// Shared types for the block-RAM arbiter: FSM encoding and packed-slice helper.
`ifndef SINGLE_PORT_BLOCKRAM_ARBITER_PKG_SV
`define SINGLE_PORT_BLOCKRAM_ARBITER_PKG_SV

// Extracts client slot idx of width w from a packed per-client vector.
`define SPBA_SLICE(vec, idx, w) vec[int'(idx)*(w) +: (w)]

package single_port_blockram_arbiter_pkg;

   typedef enum logic {
      STATE_INIT  = 1'b0,
      STATE_SERVE = 1'b1
   } state_t;

endpackage

`endif

// File: rtl/single_port_blockram_arbiter_ram.sv
// Single-port block RAM with registered read data; the array has no reset.
module single_port_blockram #(
   parameter int ENTRY_WIDTH = 64,
   parameter int DEPTH       = 64,
   parameter int ADDR_WIDTH  = $clog2(DEPTH)
) (
   input  logic                   clk_in,
   input  logic                   access_en_in,
   input  logic                   write_en_in,
   input  logic [ADDR_WIDTH-1:0]  addr_in,
   input  logic [ENTRY_WIDTH-1:0] write_data_in,
   output logic [ENTRY_WIDTH-1:0] read_data_out
);

   logic [ENTRY_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk_in) begin
      if (access_en_in) begin
         if (write_en_in) mem[addr_in] <= write_data_in;
         else             read_data_out <= mem[addr_in];
      end
   end

endmodule

// File: rtl/single_port_blockram_arbiter_rr.sv
// Combinational round-robin grant: first requester at or after the pointer, wrapping.
module round_robin_arbiter #(
   parameter int NUM_REQUESTER = 4,
   parameter int PTR_WIDTH     = $clog2(NUM_REQUESTER)
) (
   input  logic [NUM_REQUESTER-1:0] request_in,
   input  logic [PTR_WIDTH-1:0]     pointer_in,
   output logic [NUM_REQUESTER-1:0] grant_out
);

   int   idx;
   logic found;

   always_comb begin
      grant_out = '0;
      found     = 1'b0;
      idx       = 0;
      for (int i = 0; i < NUM_REQUESTER; i++) begin
         idx = int'(pointer_in) + i;
         if (idx >= NUM_REQUESTER) idx = idx - NUM_REQUESTER;
         if (!found && request_in[idx]) begin
            grant_out[idx] = 1'b1;
            found          = 1'b1;
         end
      end
   end

endmodule

// File: rtl/single_port_blockram_arbiter.sv
// Shares one single-port block RAM among several clients with round-robin arbitration,
// zero-filling the RAM after every reset and returning read data tagged with the client id.
module single_port_blockram_arbiter
   import single_port_blockram_arbiter_pkg::*;
#(
   parameter int NUM_REQUESTER             = 4,
   parameter int SINGLE_ENTRY_SIZE_IN_BITS = 64,
   parameter int NUM_SET                   = 64,
   parameter int SET_PTR_WIDTH_IN_BITS     = $clog2(NUM_SET),
   parameter int ID_WIDTH_IN_BITS          = $clog2(NUM_REQUESTER)
) (
   input  logic                                               clk_in,
   input  logic                                               reset_n_in,
   input  logic [NUM_REQUESTER-1:0]                           request_valid_in,
   input  logic [NUM_REQUESTER-1:0]                           request_write_in,
   input  logic [NUM_REQUESTER*SET_PTR_WIDTH_IN_BITS-1:0]     request_addr_in,
   input  logic [NUM_REQUESTER*SINGLE_ENTRY_SIZE_IN_BITS-1:0] request_data_in,
   output logic [NUM_REQUESTER-1:0]                           request_ack_out,
   output logic                                               init_done_out,
   output logic                                               response_valid_out,
   output logic [ID_WIDTH_IN_BITS-1:0]                        response_id_out,
   output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0]               response_data_out,
   output logic                                               debug_state_out
);

   // Handshake: a client holds valid, write, addr and data stable until it sees its ack;
   // the request is consumed on the rising edge where ack is high, and the client may
   // re-request in the following cycle. Acks are combinational and one-hot.

   state_t                                 state_q, state_d;
   logic [SET_PTR_WIDTH_IN_BITS-1:0]       init_cnt_q;
   logic [ID_WIDTH_IN_BITS-1:0]            rr_ptr_q;
   logic [ID_WIDTH_IN_BITS-1:0]            grant_id;
   logic [NUM_REQUESTER-1:0]               grant;
   logic                                   init_done_q;
   logic                                   resp_valid_q;
   logic [ID_WIDTH_IN_BITS-1:0]            resp_id_q;

   logic                                   ram_en;
   logic                                   ram_we;
   logic [SET_PTR_WIDTH_IN_BITS-1:0]       ram_addr;
   logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0]   ram_wdata;
   logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0]   ram_rdata;
   logic                                   serve_read;

   round_robin_arbiter #(
      .NUM_REQUESTER (NUM_REQUESTER),
      .PTR_WIDTH     (ID_WIDTH_IN_BITS)
   ) u_arb (
      .request_in (request_valid_in),
      .pointer_in (rr_ptr_q),
      .grant_out  (grant)
   );

   always_comb begin
      grant_id = '0;
      for (int i = 0; i < NUM_REQUESTER; i++) begin
         if (grant[i]) grant_id = ID_WIDTH_IN_BITS'(i);
      end
   end

   // RAM port belongs to the init counter during INIT and to the granted client in SERVE.
   always_comb begin
      state_d         = state_q;
      request_ack_out = '0;
      ram_en          = 1'b0;
      ram_we          = 1'b0;
      ram_addr        = init_cnt_q;
      ram_wdata       = '0;
      case (state_q)
         STATE_INIT: begin
            ram_en = 1'b1;
            ram_we = 1'b1;
            if (init_cnt_q == SET_PTR_WIDTH_IN_BITS'(NUM_SET - 1)) state_d = STATE_SERVE;
         end
         STATE_SERVE: begin
            request_ack_out = grant;
            ram_en          = |grant;
            ram_we          = request_write_in[grant_id];
            ram_addr        = `SPBA_SLICE(request_addr_in, grant_id, SET_PTR_WIDTH_IN_BITS);
            ram_wdata       = `SPBA_SLICE(request_data_in, grant_id, SINGLE_ENTRY_SIZE_IN_BITS);
         end
         default: state_d = STATE_INIT;
      endcase
   end

   assign serve_read = (state_q == STATE_SERVE) && (|grant) && !request_write_in[grant_id];

   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         state_q      <= STATE_INIT;
         init_cnt_q   <= '0;
         rr_ptr_q     <= '0;
         init_done_q  <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_id_q    <= '0;
      end else begin
         state_q      <= state_d;
         init_done_q  <= (state_d == STATE_SERVE);
         resp_valid_q <= serve_read;
         if (state_q == STATE_INIT) init_cnt_q <= init_cnt_q + 1'b1;
         if (serve_read) resp_id_q <= grant_id;
         if ((state_q == STATE_SERVE) && (|grant)) begin
            rr_ptr_q <= (grant_id == ID_WIDTH_IN_BITS'(NUM_REQUESTER - 1)) ? '0 : grant_id + 1'b1;
         end
      end
   end

   single_port_blockram #(
      .ENTRY_WIDTH (SINGLE_ENTRY_SIZE_IN_BITS),
      .DEPTH       (NUM_SET),
      .ADDR_WIDTH  (SET_PTR_WIDTH_IN_BITS)
   ) u_ram (
      .clk_in        (clk_in),
      .access_en_in  (ram_en),
      .write_en_in   (ram_we),
      .addr_in       (ram_addr),
      .write_data_in (ram_wdata),
      .read_data_out (ram_rdata)
   );

   assign init_done_out      = init_done_q;
   assign response_valid_out = resp_valid_q;
   assign response_id_out    = resp_id_q;
   assign response_data_out  = ram_rdata;
   assign debug_state_out    = state_q;

endmodule
